// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine controller and its phase timer.
// Both the controller FSM and wash_phase_timer import this package.
package wash_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_RUNNING = 2'd1,
    PH_PAUSED  = 2'd2,
    PH_DONE    = 2'd3
  } phase_state_e;

  localparam int TICKS_PER_SEC_DEF = 5;   // 200 ms system clock
  localparam int PERIOD_W_DEF      = 16;

  // Prescaler counter width: clog2(ticks), never narrower than one bit.
  function automatic int presc_w(input int ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/wash_tick_prescaler.sv
// Divides the system clock down to a one-second tick, counting only enabled
// cycles; the count freezes while enable is low and clears synchronously.
module wash_tick_prescaler
  import wash_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic sec_tick_o
);

  localparam int CNT_W = presc_w(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign sec_tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer answering the controller's timer interface: loads a period in
// seconds, counts down with pause/resume, and holds timer_done until cleared.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int PERIOD_W      = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                timer_enable,
  input  logic                timer_reset,
  input  logic [PERIOD_W-1:0] timer_period,
  output logic                timer_done,
  output logic                done_pulse,
  output logic                timer_running,
  output logic [PERIOD_W-1:0] time_remaining,
  output phase_state_e        state_dbg
);

  phase_state_e        state_q, state_d;
  logic [PERIOD_W-1:0] remaining_q, remaining_d;
  logic                done_pulse_q, done_pulse_d;
  logic                presc_en, presc_clr, sec_tick;

  // The edge that leaves PAUSED also counts, so pausing never costs an edge.
  assign presc_en  = !timer_reset && timer_enable &&
                     (state_q == PH_RUNNING || state_q == PH_PAUSED);
  assign presc_clr = timer_reset || (state_q == PH_IDLE);

  wash_tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (presc_clr),
    .enable_i  (presc_en),
    .sec_tick_o(sec_tick)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    done_pulse_d = 1'b0;
    if (timer_reset) begin
      state_d     = PH_IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        PH_IDLE: begin
          if (timer_enable) begin
            if (timer_period == '0) begin
              state_d      = PH_DONE;
              done_pulse_d = 1'b1;
            end else begin
              state_d     = PH_RUNNING;
              remaining_d = timer_period;
            end
          end
        end
        PH_RUNNING, PH_PAUSED: begin
          if (timer_enable) begin
            state_d = PH_RUNNING;
            if (sec_tick && remaining_q != '0) begin
              remaining_d = remaining_q - PERIOD_W'(1);
              if (remaining_q == PERIOD_W'(1)) begin
                state_d      = PH_DONE;
                done_pulse_d = 1'b1;
              end
            end
          end else begin
            state_d = PH_PAUSED;
          end
        end
        PH_DONE: state_d = PH_DONE;
        default: state_d = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PH_IDLE;
      remaining_q  <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign timer_done     = (state_q == PH_DONE);
  assign timer_running  = (state_q == PH_RUNNING);
  assign done_pulse     = done_pulse_q;
  assign time_remaining = remaining_q;
  assign state_dbg      = state_q;

endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
Phase timer on the responder side of the washing-machine controller's timer interface. It consumes timer_enable, timer_reset and timer_period (seconds) from the controller FSM and returns timer_done, which ends the WASH, RINSE and DRY_SPIN phases. It owns the clock-to-seconds prescaling, supports pause/resume through timer_enable and reports remaining time for display.

Parameters:
TICKS_PER_SEC, 5, clk cycles per second (200 ms clock); must be >= 1
PERIOD_W, 16, width of timer_period and time_remaining

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
timer_enable  in  1  1 = count; 0 while loaded = pause
timer_reset  in  1  synchronous clear to IDLE; priority over timer_enable
timer_period  in  PERIOD_W  phase duration in seconds; sampled only at load
timer_done  out  1  level; high in DONE until timer_reset or reset
done_pulse  out  1  single-cycle strobe on the DONE entry edge
timer_running  out  1  high in RUNNING only
time_remaining  out  PERIOD_W  whole seconds left; 0 in IDLE and DONE

Behaviour:
- Reset values: state IDLE, prescaler 0, remaining 0; timer_done, done_pulse and timer_running all 0; time_remaining 0.
- States: IDLE, RUNNING, PAUSED, DONE. Encoding is binary, 2 bits.
- Priority on every edge: reset (async) > timer_reset > state logic.
- timer_reset=1 on any edge: go to IDLE, prescaler=0, remaining=0, clear done. Applies from every state, including mid-count and DONE.
- IDLE, timer_enable=1, timer_period>0: load remaining=timer_period and prescaler=0; go to RUNNING. This edge is the load edge E0.
- IDLE, timer_enable=1, timer_period=0: go directly to DONE on that edge. done_pulse fires.
- RUNNING, timer_enable=1: prescaler increments each edge.
  - When prescaler==TICKS_PER_SEC-1, prescaler wraps to 0 and remaining decrements.
  - When that decrement takes remaining from 1 to 0, the same edge enters DONE.
- Latency: with timer_enable held, timer_done rises on edge E0 + P*TICKS_PER_SEC, where P is the loaded period.
- RUNNING, timer_enable=0: go to PAUSED. Prescaler and remaining freeze and are not lost.
- PAUSED, timer_enable=1: go to RUNNING. Counting resumes on the next edge, so total enabled edges to DONE is unchanged.
- DONE: hold timer_done=1 regardless of timer_enable. Leave only via timer_reset or reset.
- timer_period changes after load are ignored until the next load.
- done_pulse: exactly one cycle, on the edge that enters DONE. It is not re-asserted while DONE is held.
- Prescaler width: clog2(TICKS_PER_SEC), minimum 1 bit.
- TICKS_PER_SEC=1: every enabled edge decrements remaining.
- The remaining counter never underflows. The decrement is gated when remaining==0.
- Outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package wash_pkg holds:
  - phase-timer state constants (IDLE, RUNNING, PAUSED, DONE)
  - TICKS_PER_SEC default
  - PERIOD_W
  The controller FSM and this block both use wash_pkg.
- One sub-module, wash_tick_prescaler:
  - counts enabled cycles, clears synchronously
  - outputs sec_tick when count==TICKS_PER_SEC-1 and enable=1
  - the top block owns the FSM and the remaining counter

Test Plan:
- Nominal run, TICKS_PER_SEC=5, period=3, enable held: timer_done rises exactly 15 edges after E0. time_remaining steps 3→2→1→0 at edges 5, 10, 15. done_pulse is high for 1 cycle. timer_running falls on edge 15.
- Pause mid-count, period=2: drop enable after 7 enabled edges for 20 cycles, then re-enable. State is PAUSED and time_remaining=1 throughout the pause. timer_done rises after 3 more enabled edges, 10 enabled edges total.
- Zero period: enable with timer_period=0 in IDLE. DONE is entered on the same edge with timer_done=1, done_pulse=1, time_remaining=0.
- timer_reset priority: assert timer_reset and timer_enable together at edge 8 of a 3 s run. Next state is IDLE and all outputs are 0. Holding enable with reset released reloads on the following edge.
- Hold in DONE, then restart: after done, drop enable for 4 cycles and timer_done stays 1. Pulse timer_reset, then enable with period=1. timer_done is 0, then rises again 5 edges after the new E0.
- Async reset mid-run: assert reset between clock edges while RUNNING with time_remaining=2. All outputs are 0 immediately, before the next edge. Late period changes are ignored: changing timer_period to 9 after load does not alter the 15-edge timing.
